// File: rtl/osiris_wb_gpio_pkg.sv
// Shared constants, types and helpers for the osiris Wishbone GPIO/timer slave.
package osiris_wb_gpio_pkg;

  // Register word indices, compared against wbs_adr_i[4:2]
  localparam logic [2:0] OFF_OUT    = 3'd0;  // 0x00
  localparam logic [2:0] OFF_OEB    = 3'd1;  // 0x04
  localparam logic [2:0] OFF_IN     = 3'd2;  // 0x08
  localparam logic [2:0] OFF_CTRL   = 3'd3;  // 0x0C
  localparam logic [2:0] OFF_CMP    = 3'd4;  // 0x10
  localparam logic [2:0] OFF_CNT    = 3'd5;  // 0x14
  localparam logic [2:0] OFF_STATUS = 3'd6;  // 0x18

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_RELOAD = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wb_state_e;

  // Expand Wishbone byte enables into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Byte-lane merge of new write data into an existing register value
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/osiris_wb_gpio_if.sv
// Wishbone classic single-beat bus bundle between the core and the GPIO slave.
interface osiris_wb_gpio_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/osiris_wb_timer.sv
// 32-bit compare timer: free-running or one-shot up-counter with a sticky
// MATCH flag and a level interrupt gated by IRQ_EN.
module osiris_wb_timer
  import osiris_wb_gpio_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ctrl_we_i,
  input  logic        cmp_we_i,
  input  logic        cnt_we_i,
  input  logic        status_we_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] wr_mask_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic [2:0]  ctrl_o,
  output logic        match_o,
  output logic        irq_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic        hit;

  // Next-state: bus writes win over counting; a match set wins over W1C
  always_comb begin
    hit     = ctrl_q[CTRL_EN] && (cnt_q == cmp_q);
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    ctrl_d  = ctrl_q;
    match_d = match_q;

    if (cnt_we_i)
      cnt_d = merge_bytes(cnt_q, wr_data_i, wr_mask_i);
    else if (hit)
      cnt_d = ctrl_q[CTRL_RELOAD] ? 32'd0 : cnt_q;
    else if (ctrl_q[CTRL_EN])
      cnt_d = cnt_q + 32'd1;

    if (cmp_we_i)
      cmp_d = merge_bytes(cmp_q, wr_data_i, wr_mask_i);

    if (ctrl_we_i)
      ctrl_d = (ctrl_q & ~wr_mask_i[2:0]) | (wr_data_i[2:0] & wr_mask_i[2:0]);
    else if (hit && !ctrl_q[CTRL_RELOAD])
      ctrl_d[CTRL_EN] = 1'b0;

    if (hit)
      match_d = 1'b1;
    else if (status_we_i && wr_mask_i[0] && wr_data_i[0])
      match_d = 1'b0;
  end

  // Timer state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= 32'd0;
      cmp_q   <= 32'hFFFF_FFFF;
      ctrl_q  <= 3'd0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cmp_o   = cmp_q;
  assign ctrl_o  = ctrl_q;
  assign match_o = match_q;
  assign irq_o   = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/osiris_wb_gpio.sv
// Wishbone classic slave for the 16 user IO pads plus the compare timer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a selected strobe; write/read committed on exit
// ST_ACK  | ack high for this single cycle, then back to idle
module osiris_wb_gpio
  import osiris_wb_gpio_pkg::*;
#(
  parameter int          BITS      = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  osiris_wb_gpio_if.slave  wb,
  input  logic [BITS-1:0]  io_in,
  output logic [BITS-1:0]  io_out,
  output logic [BITS-1:0]  io_oeb,
  output logic             irq
);

  wb_state_e       state_q;
  logic            ack_q;
  logic [31:0]     dat_q;
  logic [BITS-1:0] out_q, oeb_q;
  logic [BITS-1:0] sync1_q, sync2_q;

  logic        sel_hit, commit, wr;
  logic [2:0]  off;
  logic [31:0] wmask, rd_data;
  logic [31:0] cnt, cmp;
  logic [2:0]  ctrl;
  logic        match;
  logic        unused_adr;

  assign sel_hit    = wb.wbs_cyc_i && wb.wbs_stb_i &&
                      (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign commit     = (state_q == ST_IDLE) && sel_hit;
  assign wr         = commit && wb.wbs_we_i;
  assign off        = wb.wbs_adr_i[4:2];
  assign wmask      = byte_mask(wb.wbs_sel_i);
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  // Readback mux; narrow fields are zero-extended, 0x1C reads zero
  always_comb begin
    rd_data = 32'd0;
    case (off)
      OFF_OUT:    rd_data = 32'(out_q);
      OFF_OEB:    rd_data = 32'(oeb_q);
      OFF_IN:     rd_data = 32'(sync2_q);
      OFF_CTRL:   rd_data = 32'(ctrl);
      OFF_CMP:    rd_data = cmp;
      OFF_CNT:    rd_data = cnt;
      OFF_STATUS: rd_data = {31'd0, match};
      default:    rd_data = 32'd0;
    endcase
  end

  // Ack FSM with registered ack and read data
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_hit) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            dat_q   <= wb.wbs_we_i ? 32'd0 : rd_data;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          dat_q   <= 32'd0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          dat_q   <= 32'd0;
        end
      endcase
    end
  end

  // Pad output data and output-enable registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q <= '0;
      oeb_q <= '1;
    end else begin
      if (wr && off == OFF_OUT)
        out_q <= (out_q & ~wmask[BITS-1:0]) | (wb.wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
      if (wr && off == OFF_OEB)
        oeb_q <= (oeb_q & ~wmask[BITS-1:0]) | (wb.wbs_dat_i[BITS-1:0] & wmask[BITS-1:0]);
    end
  end

  // Two-flop synchronizer for the asynchronous pad inputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  end

  osiris_wb_timer u_timer (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .ctrl_we_i   (wr && off == OFF_CTRL),
    .cmp_we_i    (wr && off == OFF_CMP),
    .cnt_we_i    (wr && off == OFF_CNT),
    .status_we_i (wr && off == OFF_STATUS),
    .wr_data_i   (wb.wbs_dat_i),
    .wr_mask_i   (wmask),
    .cnt_o       (cnt),
    .cmp_o       (cmp),
    .ctrl_o      (ctrl),
    .match_o     (match),
    .irq_o       (irq)
  );

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign io_out       = out_q;
  assign io_oeb       = oeb_q;

endmodule
